// File: rtl/inst_decoder_pipe_if.sv
// Instruction-decoder stream interface.
// Carries the incoming instruction stream (inst_valid/inst_ready/inst) and the
// decoded output beat (out_valid/out_ready plus decoded control fields).
//   master : instruction source and decoded-beat consumer (fetch/ALU side)
//   slave  : the decoder itself
interface inst_decoder_pipe_if #(
  parameter int unsigned REG_AW = 2
);
  localparam int unsigned IW = 4 + REG_AW;

  logic              inst_valid;
  logic              inst_ready;
  logic [IW-1:0]     inst;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        op;
  logic [REG_AW-1:0] a;
  logic              ce_reg;
  logic              ce_a;
  logic              ce_cy;
  logic              imm_sel;
  logic              jump;
  logic [IW-1:0]     imm;

  modport master (
    output inst_valid, inst, out_ready,
    input  inst_ready, out_valid, op, a, ce_reg, ce_a, ce_cy, imm_sel, jump, imm
  );

  modport slave (
    input  inst_valid, inst, out_ready,
    output inst_ready, out_valid, op, a, ce_reg, ce_a, ce_cy, imm_sel, jump, imm
  );
endinterface

// File: rtl/inst_decoder_pipe.sv
// Registered, handshaked instruction decoder for the accumulator machine.
// Decodes single-word ALU ops into opcode, register address and write enables,
// and handles the two-word instructions LDI/JMP (opcode word then operand word)
// plus HALT. One output register, no skid buffer.
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : asynchronous, active-high reset
//   bus      : inst_decoder_pipe_if.slave (instruction stream in, decoded beat out)
//   halted   : HALT executed; cleared only by rst
//   inst_cnt : (only with DECODER_PERF_EN defined) saturating count of consumed beats
// Optional feature macro: DECODER_PERF_EN.
module inst_decoder_pipe #(
  parameter int unsigned REG_AW   = 2,
  parameter bit          NOP_PASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  inst_decoder_pipe_if.slave  bus,
`ifdef DECODER_PERF_EN
  output logic [15:0]         inst_cnt,
`endif
  output logic                halted
);
  localparam int unsigned IW = 4 + REG_AW;

  typedef enum logic [1:0] {StOp, StImm, StHalt} state_e;

  state_e            state_q;
  logic              is_jmp_q;  // pending two-word instruction is JMP (else LDI)
  logic              out_valid_q;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] a_q;
  logic              ce_reg_q;
  logic              ce_a_q;
  logic              ce_cy_q;
  logic              imm_sel_q;
  logic              jump_q;
  logic [IW-1:0]     imm_q;
  logic              halted_q;

  logic              inst_ready;
  logic              accept;
  logic              beat_taken;
  logic              is_class_f;
  logic [1:0]        sub_op;
  logic [2:0]        dec_op;
  logic [REG_AW-1:0] dec_a;
  logic              dec_ce_reg;
  logic              dec_ce_a;
  logic              dec_ce_cy;

  // Held low during reset so nothing is accepted while rst is asserted.
  assign inst_ready = !rst && (state_q != StHalt) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.inst_valid && inst_ready;
  assign beat_taken = out_valid_q && bus.out_ready;

  always_comb begin
    is_class_f = (bus.inst[IW-1 -: 4] == 4'b1111);
    sub_op     = bus.inst[1:0];
    dec_op     = bus.inst[IW-2 -: 3];
    dec_a      = bus.inst[REG_AW-1:0];
    dec_ce_reg = (bus.inst[IW-1 -: 4] == 4'b0111);
    dec_ce_a   = (dec_op != 3'b111);
    dec_ce_cy  = (dec_op[2:1] != 2'b11);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StOp;
      is_jmp_q    <= 1'b0;
      out_valid_q <= 1'b0;
      op_q        <= 3'b000;
      a_q         <= '0;
      ce_reg_q    <= 1'b0;
      ce_a_q      <= 1'b0;
      ce_cy_q     <= 1'b0;
      imm_sel_q   <= 1'b0;
      jump_q      <= 1'b0;
      imm_q       <= '0;
      halted_q    <= 1'b0;
    end else begin
      // A consumed beat clears; overridden below if a new beat is produced.
      if (beat_taken) out_valid_q <= 1'b0;

      if (accept) begin
        unique case (state_q)
          StOp: begin
            if (is_class_f) begin
              unique case (sub_op)
                2'd0: begin
                  if (NOP_PASS) begin
                    out_valid_q <= 1'b1;
                    op_q        <= 3'b000;
                    a_q         <= '0;
                    ce_reg_q    <= 1'b0;
                    ce_a_q      <= 1'b0;
                    ce_cy_q     <= 1'b0;
                    imm_sel_q   <= 1'b0;
                    jump_q      <= 1'b0;
                    imm_q       <= '0;
                  end
                end
                2'd1, 2'd2: begin
                  is_jmp_q <= (sub_op == 2'd2);
                  state_q  <= StImm;
                end
                2'd3: begin
                  halted_q <= 1'b1;
                  state_q  <= StHalt;
                end
              endcase
            end else begin
              out_valid_q <= 1'b1;
              op_q        <= dec_op;
              a_q         <= dec_a;
              ce_reg_q    <= dec_ce_reg;
              ce_a_q      <= dec_ce_a;
              ce_cy_q     <= dec_ce_cy;
              imm_sel_q   <= 1'b0;
              jump_q      <= 1'b0;
              imm_q       <= '0;
            end
          end
          StImm: begin
            // Operand word is passed through verbatim, never decoded.
            out_valid_q <= 1'b1;
            op_q        <= is_jmp_q ? 3'b000 : 3'b110;
            a_q         <= '0;
            ce_reg_q    <= 1'b0;
            ce_a_q      <= !is_jmp_q;
            ce_cy_q     <= 1'b0;
            imm_sel_q   <= !is_jmp_q;
            jump_q      <= is_jmp_q;
            imm_q       <= bus.inst;
            state_q     <= StOp;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bus.inst_ready = inst_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.op         = op_q;
  assign bus.a          = a_q;
  assign bus.ce_reg     = ce_reg_q;
  assign bus.ce_a       = ce_a_q;
  assign bus.ce_cy      = ce_cy_q;
  assign bus.imm_sel    = imm_sel_q;
  assign bus.jump       = jump_q;
  assign bus.imm        = imm_q;
  assign halted         = halted_q;

`ifdef DECODER_PERF_EN
  logic [15:0] inst_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_cnt_q <= 16'h0000;
    end else if (beat_taken && (inst_cnt_q != 16'hFFFF)) begin
      inst_cnt_q <= inst_cnt_q + 16'h0001;
    end
  end

  assign inst_cnt = inst_cnt_q;
`else
  // No beat counter in this build.
`endif
endmodule

// File: tb/tb_inst_decoder_pipe.sv
// Directed self-checking bench for inst_decoder_pipe (REG_AW=2, NOP_PASS=1).
module tb_inst_decoder_pipe;
  logic clk;
  logic rst;
  logic halted;
`ifdef DECODER_PERF_EN
  logic [15:0] inst_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  inst_decoder_pipe_if #(.REG_AW(2)) bus ();

  inst_decoder_pipe #(
    .REG_AW   (2),
    .NOP_PASS (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef DECODER_PERF_EN
    .inst_cnt (inst_cnt),
`endif
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [2:0] op, input logic [1:0] a,
                            input logic ce_reg, input logic ce_a, input logic ce_cy,
                            input logic imm_sel, input logic jump, input logic [5:0] imm);
    check({tag, ".valid"}, bus.out_valid, 1'b1);
    check({tag, ".op"}, bus.op, op);
    check({tag, ".a"}, bus.a, a);
    check({tag, ".ce"}, {bus.ce_reg, bus.ce_a, bus.ce_cy}, {ce_reg, ce_a, ce_cy});
    check({tag, ".sel"}, {bus.imm_sel, bus.jump}, {imm_sel, jump});
    check({tag, ".imm"}, bus.imm, imm);
  endtask

  initial begin
    int ready_seen;
    rst            = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.out_ready  = 1'b1;
    #12;
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.inst_ready", bus.inst_ready, 1'b0);
    check("rst.halted", halted, 1'b0);
    check("rst.fields", {bus.op, bus.a, bus.imm}, '0);
    rst = 1'b0;
    #1;
    check("idle.inst_ready", bus.inst_ready, 1'b1);

    // 1: plain ALU op
    bus.inst_valid = 1'b1;
    bus.inst = 6'b001101;
    step();
    check_beat("alu", 3'b011, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    check("alu.inst_ready", bus.inst_ready, 1'b1);

    // 2: ST r2 then LD back-to-back
    bus.inst = 6'b011110;
    step();
    check_beat("st", 3'b111, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    bus.inst = 6'b011001;
    step();
    check_beat("ld", 3'b110, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);

    // 3: LDI + operand
    bus.inst = 6'b111101;
    step();
    check("ldi.nobeat", bus.out_valid, 1'b0);
    bus.inst = 6'b101010;
    step();
    check_beat("ldi", 3'b110, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b101010);
    bus.inst_valid = 1'b0;
    step();
    check("ldi.cleared", bus.out_valid, 1'b0);

    // 4: JMP + operand, back-pressured for 3 cycles
    bus.inst_valid = 1'b1;
    bus.inst = 6'b111110;
    step();
    check("jmp.nobeat", bus.out_valid, 1'b0);
    bus.inst = 6'b000011;
    bus.out_ready = 1'b0;
    step();
    check_beat("jmp", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011);
    bus.inst = 6'b001101;
    for (int i = 0; i < 3; i++) begin
      check("stall.inst_ready", bus.inst_ready, 1'b0);
      step();
      check_beat("stall", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011);
    end
    bus.inst_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("release.inst_ready", bus.inst_ready, 1'b1);
    step();
    check("release.consumed", bus.out_valid, 1'b0);

    // NOP passes through with all enables low
    bus.inst_valid = 1'b1;
    bus.inst = 6'b111100;
    step();
    check("nop.valid", bus.out_valid, 1'b1);
    check("nop.ce", {bus.ce_reg, bus.ce_a, bus.ce_cy, bus.imm_sel, bus.jump}, 5'b0);

    // 5: HALT, then recover via mid-cycle reset
    bus.inst = 6'b111111;
    step();
    check("halt.halted", halted, 1'b1);
    check("halt.out_valid", bus.out_valid, 1'b0);
    bus.inst = 6'b001101;
    ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.inst_ready || bus.out_valid) ready_seen++;
      step();
    end
    check("halt.stuck", ready_seen, 0);
    check("halt.still", halted, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("halt.rst_async", halted, 1'b0);
    check("halt.rst_ready", bus.inst_ready, 1'b0);
    rst = 1'b0;
    step();
    check_beat("post_halt", 3'b011, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);

    // 6: pending operand dropped by reset
    bus.inst = 6'b111101;
    step();
    #2 rst = 1'b1;
    #1;
    check("drop.out_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    bus.inst = 6'b001000;
    step();
    check_beat("drop", 3'b010, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    bus.inst_valid = 1'b0;
    step();
`ifdef DECODER_PERF_EN
    check("perf.inst_cnt", inst_cnt, 16'd1);
`endif
    check("end.out_valid", bus.out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
